// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux select arbiter: requester count, index width,
// arbiter state type and a one-hot helper.
package mux_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux_select_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request searching upward from
// ptr with wrap-around.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] cand;

   // Walk from the farthest offset back to ptr so the nearest hit is written last.
   always_comb begin
      valid = 1'b0;
      idx   = ptr;
      cand  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = ptr + IDX_W'(i);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin owner arbiter driving a 4:1 selector's S lines, with one dead cycle
// between owners. Optional hold limit enabled by macro ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner, arbitrating every cycle
// OWN   | grant held for owner sel while its request stays high
// GAP   | one dead cycle after release, arbitrating for the next owner
module mux_select_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 8
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REQ-1:0]  req,
   output logic [NUM_REQ-1:0]  grant,
   output logic [IDX_W-1:0]    sel,
   output logic                busy,
   output logic                timeout
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255 || MAX_HOLD >= (1 << CNT_W)) begin : g_bad_max_hold
      $error("mux_select_arbiter: MAX_HOLD out of range for CNT_W");
   end

   arb_state_t          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]    sel_q, sel_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_valid;
   logic                owner_req;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic                timeout_q, timeout_d;
   logic                hold_at_limit;

   // Counter holds completed OWN cycles, so the limit cycle is the MAX_HOLD-th.
   assign hold_at_limit = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

   rr_pick u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign owner_req = req[sel_q];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
`endif
      case (state_q)
         IDLE, GAP: begin
            if (pick_valid) begin
               state_d = OWN;
               grant_d = idx_to_onehot(pick_idx);
               sel_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_d = '0;
`endif
            end else begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         OWN: begin
            if (!owner_req) begin
               state_d = GAP;
               grant_d = '0;
               ptr_d   = sel_q + IDX_W'(1);
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_at_limit) begin
               state_d   = GAP;
               grant_d   = '0;
               ptr_d     = sel_q + IDX_W'(1);
               timeout_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
`endif
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign grant = grant_q;
   assign sel   = sel_q;
   assign busy  = (state_q == OWN);

`ifdef ARB_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter; hold-limit checks follow ARB_TIMEOUT_EN.
module tb_mux_select_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;
   logic       timeout;

   int n_chk  = 0;
   int n_pass = 0;

   logic       mon_en    = 1'b0;
   logic       prev_busy = 1'b0;
   logic [1:0] prev_sel  = 2'd0;

   mux_select_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .grant   (grant),
      .sel     (sel),
      .busy    (busy),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                          input logic b, input logic t);
      chk({tag, ".grant"}, grant, g);
      chk({tag, ".sel"}, sel, s);
      chk({tag, ".busy"}, busy, b);
      chk({tag, ".timeout"}, timeout, t);
   endtask

   function automatic logic [3:0] oh(input int i);
      logic [3:0] v;
      v    = 4'b0000;
      v[i] = 1'b1;
      return v;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_onehot", ($countones(grant) <= 1), 1);
         if (busy) chk("mon_grant_sel", grant[sel], 1);
         if (busy && prev_busy) chk("mon_sel_stable", sel, prev_sel);
         prev_busy = busy;
         prev_sel  = sel;
      end
   end

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      tick();
      tick();
      chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < 10; i++) begin
         tick();
         chk_out("idle_quiet", 4'b0000, 2'd0, 1'b0, 1'b0);
      end

      // two requesters from ptr 0: 1 then 3 with one dead cycle
      req = 4'b1010;
      tick();
      chk_out("pair_first", 4'b0010, 2'd1, 1'b1, 1'b0);
      tick();
      chk_out("pair_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b1000;
      tick();
      chk_out("pair_gap", 4'b0000, 2'd1, 1'b0, 1'b0);
      tick();
      chk_out("pair_second", 4'b1000, 2'd3, 1'b1, 1'b0);
      req = 4'b0000;
      tick();
      chk_out("pair_release", 4'b0000, 2'd3, 1'b0, 1'b0);
      tick();
      chk_out("pair_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

      // all request, each owner drops one cycle: 0,1,2,3,0
      req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk_out("rr_own", oh(k % 4), 2'(k % 4), 1'b1, 1'b0);
         req = 4'b1111 & ~oh(k % 4);
         tick();
         chk_out("rr_gap", 4'b0000, 2'(k % 4), 1'b0, 1'b0);
         req = 4'b1111;
         tick();
      end
      chk_out("rr_last", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b0000;
      tick();
      tick();
      chk_out("rr_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

      // reset while requester 2 owns
      req = 4'b0100;
      tick();
      chk_out("pre_reset_own", 4'b0100, 2'd2, 1'b1, 1'b0);
      rst_n = 1'b0;
      tick();
      chk_out("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      req   = 4'b0110;
      tick();
      chk_out("post_reset", 4'b0010, 2'd1, 1'b1, 1'b0);

      // owner 1 drops while 0 and 2 wait, then re-asserts in GAP
      req = 4'b0101;
      tick();
      chk_out("reassert_gap", 4'b0000, 2'd1, 1'b0, 1'b0);
      req = 4'b0111;
      tick();
      chk_out("reassert_pick", 4'b0100, 2'd2, 1'b1, 1'b0);
      req = 4'b0011;
      tick();
      chk_out("wrap_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
      tick();
      chk_out("wrap_pick", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b0000;
      tick();
      tick();
      chk_out("wrap_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

      req = 4'b0001;
      tick();
      chk_out("hold_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("hold_cn", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      tick();
      chk_out("forced_gap", 4'b0000, 2'd0, 1'b0, 1'b1);
      tick();
      chk_out("regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("regrant_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      req = 4'b0000;
      tick();
      chk_out("vol_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_out("unlimited", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      req = 4'b0000;
      tick();
      chk_out("unlimited_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif
      tick();
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
